// File: rtl/y_sig_pkg.sv
// Shared types and helpers for the y-bus signature compactor.
package y_sig_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of sig_w-bit chunks needed to cover a width-bit bus.
  function automatic int unsigned fold_chunks(input int unsigned width, input int unsigned sig_w);
    return (width + sig_w - 1) / sig_w;
  endfunction

endpackage

// File: rtl/misr_step.sv
// One MISR step: shift with polynomial feedback, then XOR in the folded y bus.
module misr_step
  import y_sig_pkg::*;
#(
  parameter int unsigned       WIDTH = 82,
  parameter int unsigned       SIG_W = 32,
  parameter logic [SIG_W-1:0]  POLY  = 32'h04C11DB7
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [WIDTH-1:0] y,
  output logic [SIG_W-1:0] next_sig_c
);

  localparam int unsigned NCH   = fold_chunks(WIDTH, SIG_W);
  localparam int unsigned PAD_W = NCH * SIG_W;

  logic [PAD_W-1:0] y_pad;
  logic [SIG_W-1:0] fold;

  // Zero-pad y to whole chunks, XOR the chunks together, then apply the LFSR shift.
  always_comb begin
    y_pad = PAD_W'(y);
    fold  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fold = fold ^ y_pad[i*SIG_W +: SIG_W];
    end
    next_sig_c = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

endmodule

// File: rtl/y_signature_misr.sv
// Response compactor for the DUT result bus y: skip warm-up edges, fold NSAMP
// samples into a MISR, then compare against a golden signature.
// Optional feature macro: MISR_TOGGLE_CNT_EN adds toggle_cnt (captures where y changed).
module y_signature_misr #(
  parameter int unsigned       WIDTH = 82,
  parameter int unsigned       SIG_W = 32,
  parameter logic [SIG_W-1:0]  POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED  = 32'hFFFFFFFF,
  parameter int unsigned       SKIP  = 2,
  parameter int unsigned       NSAMP = 21
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              y,
  input  logic [SIG_W-1:0]              expected,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [SIG_W-1:0]              signature,
  output logic [y_sig_pkg::CNT_W-1:0]   sample_cnt
`ifdef MISR_TOGGLE_CNT_EN
  ,
  output logic [y_sig_pkg::CNT_W-1:0]   toggle_cnt
`endif
);

  import y_sig_pkg::*;

  localparam state_t            RUN_ST  = (SKIP == 0) ? y_sig_pkg::CAPT : y_sig_pkg::SKIP;
  localparam logic [CNT_W-1:0]  SKIP_N  = CNT_W'(SKIP);
  localparam logic [CNT_W-1:0]  NSAMP_N = CNT_W'(NSAMP);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d, step_c;
  logic [CNT_W-1:0] samp_q, samp_d, skip_q, skip_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
`ifdef MISR_TOGGLE_CNT_EN
  logic [WIDTH-1:0] prev_y_q, prev_y_d;
  logic [CNT_W-1:0] tog_q, tog_d;
`endif

  misr_step #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig        (sig_q),
    .y          (y),
    .next_sig_c (step_c)
  );

  // Next-state and datapath updates; start restarts from any state.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    samp_d  = samp_q;
    skip_d  = skip_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef MISR_TOGGLE_CNT_EN
    prev_y_d = prev_y_q;
    tog_d    = tog_q;
`endif
    if (start) begin
      state_d = RUN_ST;
      sig_d   = SEED;
      samp_d  = '0;
      skip_d  = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
`ifdef MISR_TOGGLE_CNT_EN
      prev_y_d = '0;
      tog_d    = '0;
`endif
    end else begin
      case (state_q)
        y_sig_pkg::IDLE: begin
        end
        y_sig_pkg::SKIP: begin
          skip_d = skip_q + CNT_W'(1);
          if (skip_d == SKIP_N) state_d = y_sig_pkg::CAPT;
        end
        y_sig_pkg::CAPT: begin
          sig_d = step_c;
          if (samp_q != '1) samp_d = samp_q + CNT_W'(1);
          if (samp_d == NSAMP_N) state_d = y_sig_pkg::DONE;
`ifdef MISR_TOGGLE_CNT_EN
          if ((y != prev_y_q) && (tog_q != '1)) tog_d = tog_q + CNT_W'(1);
          prev_y_d = y;
`endif
        end
        y_sig_pkg::DONE: begin
          // First edge in DONE sees the final signature; result then held.
          if (!done_q) begin
            done_d = 1'b1;
            pass_d = (sig_q == expected);
          end
        end
        default: state_d = y_sig_pkg::IDLE;
      endcase
    end
    busy_d = (state_d == y_sig_pkg::SKIP) || (state_d == y_sig_pkg::CAPT);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= y_sig_pkg::IDLE;
      sig_q   <= SEED;
      samp_q  <= '0;
      skip_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef MISR_TOGGLE_CNT_EN
      prev_y_q <= '0;
      tog_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      samp_q  <= samp_d;
      skip_q  <= skip_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef MISR_TOGGLE_CNT_EN
      prev_y_q <= prev_y_d;
      tog_q    <= tog_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign sample_cnt = samp_q;
`ifdef MISR_TOGGLE_CNT_EN
  assign toggle_cnt = tog_q;
`endif

endmodule
